// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM states, buffer entry layout,
// and the fetch stride.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/fetch_buf.sv
// Prefetch FIFO of fetched {pc, inst} entries with push/pop/flush and occupancy count.
// The head output reads as zero while the FIFO is empty.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  fetch_entry_t                 i_wdata,
  output fetch_entry_t                 o_rdata,
  output logic [$clog2(BUF_DEPTH):0]   o_count
);

  localparam int unsigned PW = $clog2(BUF_DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t      r_mem [BUF_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  always_ff @(posedge clk_i) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives instruction-memory addresses,
// buffers returned words with their PCs and hands them to decode via valid/ready.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_W    = 13,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fetch_en_i,
  input  logic              redirect_valid_i,
  input  logic [31:0]       redirect_pc_i,
  output logic [IMEM_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_rdata_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [31:0]       inst_o,
  output logic [31:0]       inst_pc_o
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_C = CW'(BUF_DEPTH);

  fetch_state_e  r_state;
  fetch_state_e  w_state_next;
  logic          w_fetch_phase;
  logic [31:0]   r_pc;
  logic [31:0]   w_redirect_pc;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_wdata;
  fetch_entry_t  w_head;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_BOOT;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_BOOT: w_state_next = fetch_en_i ? ST_RUN : ST_HALT;
      ST_RUN:  if (!fetch_en_i) w_state_next = ST_HALT;
      ST_HALT: if (fetch_en_i)  w_state_next = ST_RUN;
      default: w_state_next = ST_BOOT;
    endcase
  end

  always_comb begin
    w_fetch_phase = (r_state == ST_RUN);
  end

  assign w_redirect_pc = redirect_pc_i & ~32'h0000_0003;

  // Redirect outranks everything: it masks valid (so no pop) and suppresses push.
  assign inst_valid_o = (w_count != '0) && !redirect_valid_i;
  assign w_pop        = inst_valid_o && inst_ready_i;
  assign w_push       = w_fetch_phase && fetch_en_i && !redirect_valid_i &&
                        ((w_count < FULL_C) || w_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 r_pc <= RESET_PC;
    else if (redirect_valid_i) r_pc <= w_redirect_pc;
    else if (w_push)           r_pc <= r_pc + 32'(INST_BYTES);
  end

  assign imem_addr_o = r_pc[IMEM_W-1:0];
  assign w_wdata     = '{pc: r_pc, inst: imem_rdata_i};

  fetch_buf #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid_i),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  assign inst_o    = w_head.inst;
  assign inst_pc_o = w_head.pc;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboarded bench for imem_fetch_ctrl: stimulus queues the PCs decode must receive,
// a negedge monitor pops and checks every accepted instruction.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_en;
  logic        redir;
  logic [31:0] redir_pc;
  logic [12:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // Memory image: word n holds 32'h1000_0000 + n.
  assign imem_rdata = 32'h1000_0000 + {19'b0, imem_addr[12:2]};

  imem_fetch_ctrl #(
    .IMEM_W    (13),
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .fetch_en_i       (fetch_en),
    .redirect_valid_i (redir),
    .redirect_pc_i    (redir_pc),
    .imem_addr_o      (imem_addr),
    .imem_rdata_i     (imem_rdata),
    .inst_valid_o     (inst_valid),
    .inst_ready_i     (inst_ready),
    .inst_o           (inst),
    .inst_pc_o        (inst_pc)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pcs(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(4 * i));
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_valid"}, {31'b0, inst_valid}, 32'h0);
    chk({nm, "_inst"}, inst, 32'h0);
    chk({nm, "_pc"}, inst_pc, 32'h0);
    chk({nm, "_addr"}, {19'b0, imem_addr}, 32'h0);
  endtask

  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_delivery: got pc %h expected none", inst_pc);
      end else begin
        logic [31:0] epc;
        logic [31:0] einst;
        epc   = exp_q.pop_front();
        einst = 32'h1000_0000 + {19'b0, epc[12:2]};
        chk("deliver_pc", inst_pc, epc);
        chk("deliver_inst", inst, einst);
      end
    end
  end

  initial begin
    fetch_en   = 1'b1;
    inst_ready = 1'b1;
    redir      = 1'b0;
    redir_pc   = 32'h0;
    #1 rst = 1'b1;
    #2 chk_reset_outs("reset");

    @(posedge clk); #1 rst = 1'b0;
    #1 chk("boot_valid", {31'b0, inst_valid}, 32'h0);
    expect_pcs(32'h0, 4);

    adv(1); #1 chk("run_addr0", {19'b0, imem_addr}, 32'h0);
    chk("run_valid0", {31'b0, inst_valid}, 32'h0);
    adv(1); #1 chk("first_valid", {31'b0, inst_valid}, 32'h1);
    chk("first_addr", {19'b0, imem_addr}, 32'h4);

    adv(4); inst_ready = 1'b0;
    #1 chk("stall_addr_a", {19'b0, imem_addr}, 32'd20);
    adv(3); #1 chk("full_addr_hold", {19'b0, imem_addr}, 32'd24);
    chk("full_head_pc", inst_pc, 32'd16);
    adv(2); inst_ready = 1'b1; expect_pcs(32'd16, 3);
    #1 chk("full_addr_hold2", {19'b0, imem_addr}, 32'd24);

    adv(3); inst_ready = 1'b0;
    adv(1); redir = 1'b1; redir_pc = 32'h0000_0103;
    #1 chk("redir_mask", {31'b0, inst_valid}, 32'h0);
    chk("redir_addr_old", {19'b0, imem_addr}, 32'd36);
    adv(1); redir = 1'b0;
    #1 chk("flush_empty", {31'b0, inst_valid}, 32'h0);
    chk("redir_addr", {19'b0, imem_addr}, 32'h100);

    adv(2); fetch_en = 1'b0; inst_ready = 1'b1; expect_pcs(32'h100, 2);
    #1 chk("halt_addr", {19'b0, imem_addr}, 32'h108);
    adv(2); #1 chk("halt_drained", {31'b0, inst_valid}, 32'h0);
    adv(2); #1 chk("halt_valid", {31'b0, inst_valid}, 32'h0);
    chk("halt_hold", {19'b0, imem_addr}, 32'h108);
    fetch_en = 1'b1; expect_pcs(32'h108, 2);

    adv(4); redir = 1'b1; redir_pc = 32'h0000_1FF8;
    #1 chk("redir2_mask", {31'b0, inst_valid}, 32'h0);
    adv(1); redir = 1'b0; expect_pcs(32'h1FF8, 4);
    #1 chk("wrap_start", {19'b0, imem_addr}, 32'h1FF8);
    adv(2); #1 chk("alias_addr", {19'b0, imem_addr}, 32'h0);

    adv(3); inst_ready = 1'b0;
    adv(1);
    chk("pending_pre_rst", 32'(exp_q.size()), 32'h0);
    #2 rst = 1'b1;
    #1 chk_reset_outs("async_rst");

    @(posedge clk); #1 rst = 1'b0; inst_ready = 1'b1; expect_pcs(32'h0, 2);
    #1 chk("reboot_valid", {31'b0, inst_valid}, 32'h0);
    adv(1); #1 chk("reboot_addr", {19'b0, imem_addr}, 32'h0);
    chk("reboot_run_valid", {31'b0, inst_valid}, 32'h0);
    adv(2); fetch_en = 1'b0;
    adv(3); #1 chk("end_valid", {31'b0, inst_valid}, 32'h0);
    chk("end_addr", {19'b0, imem_addr}, 32'h8);
    chk("pending_end", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Instruction-fetch sequencer for the combinational-read instruction memory. It owns the fetch PC and drives the word address to instruction memory each cycle. It captures each returned word with its PC into a small prefetch buffer and presents entries to decode through a valid/ready handshake. It handles branch/jump redirects by flushing the buffer and a fetch-enable gate by halting the PC.

Parameters:
IMEM_W, 13, byte-address width of instruction memory (2**(IMEM_W-2) words)
RESET_PC, 32'h0000_0000, fetch PC after reset; must be 4-byte aligned
BUF_DEPTH, 2, prefetch buffer entries (power of two, >=2)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous, active-high reset
fetch_en_i  input  1  1 = fetch allowed; 0 = hold PC, buffer keeps draining
redirect_valid_i  input  1  taken branch/jump this cycle
redirect_pc_i  input  32  redirect target byte address
imem_addr_o  output  IMEM_W  byte address to instruction memory (pc_q[IMEM_W-1:0])
imem_rdata_i  input  32  instruction word, combinationally valid for imem_addr_o in same cycle
inst_valid_o  output  1  head entry valid
inst_ready_i  input  1  decode accepts head entry
inst_o  output  32  head instruction
inst_pc_o  output  32  head PC

Behaviour:
- Reset (async assert, sync-to-clock release): pc_q=RESET_PC, buffer empty (count=0, rd/wr ptr=0), state=ST_BOOT. Outputs: inst_valid_o=0, inst_o=0, inst_pc_o=0, imem_addr_o=RESET_PC[IMEM_W-1:0]. Reset mid-operation discards all buffered entries.
- FSM:
  - ST_BOOT: one cycle with no fetch, then go to ST_RUN if fetch_en_i=1, else ST_HALT.
  - ST_RUN: go to ST_HALT when fetch_en_i=0.
  - ST_HALT: go to ST_RUN when fetch_en_i=1.
  - Redirect does not change state.
- push = (state==ST_RUN) & fetch_en_i & ~redirect_valid_i & (count<BUF_DEPTH | pop).
  - On push, write {pc_q, imem_rdata_i} at wr_ptr and set pc_q<=pc_q+4.
  - Latency: address-to-entry is 0 cycles. An entry pushed at edge N is visible on inst_valid_o in cycle N+1.
- pop = inst_valid_o & inst_ready_i; advances rd_ptr.
- inst_valid_o = (count!=0) & ~redirect_valid_i, masked combinationally in the redirect cycle. inst_o/inst_pc_o = head entry when count!=0, else 0.
- Simultaneous push and pop when full: allowed, count unchanged. Push and pop when count=1: count unchanged.
- Redirect (priority over push, pop and fetch_en_i):
  - Next edge: count=0, ptrs=0, pc_q<={redirect_pc_i[31:2],2'b00}. Misaligned low bits are silently cleared.
  - A redirect in ST_HALT or ST_BOOT still loads pc_q.
  - Back-to-back redirects: the last one wins.
- fetch_en_i=0: no push, pc_q held, decode may continue draining buffered entries.
- Wrap-around:
  - pc_q wraps modulo 2**32.
  - imem_addr_o uses only pc_q[IMEM_W-1:0], so addresses beyond memory size alias; no error is flagged.
  - Buffer pointers wrap modulo BUF_DEPTH.
- count width = $clog2(BUF_DEPTH)+1. Never exceeds BUF_DEPTH; never underflows (pop requires valid).

Decomposition:
- Package fetch_pkg:
  - fetch_state_e {ST_BOOT, ST_RUN, ST_HALT}
  - fetch_entry_t packed struct {logic [31:0] pc; logic [31:0] inst;}
  - localparam INST_BYTES=4
- Sub-module fetch_buf: BUF_DEPTH-entry synchronous FIFO of fetch_entry_t with push/pop/flush and count. It uses the same clk_i/rst_i and is instantiated once.
- PC register, FSM and push/redirect logic stay in imem_fetch_ctrl.

Test Plan:
- Reset release, fetch_en_i=1, inst_ready_i=1, memory word n = 32'h1000_0000+n:
  - cycle after ST_BOOT shows address 0;
  - inst_valid_o rises one cycle later with inst_o=32'h1000_0000, inst_pc_o=0;
  - then one instruction per cycle with PCs 4, 8, 12.
- inst_ready_i=0 for 5 cycles:
  - buffer fills to 2 entries (PC 0, 4) and imem_addr_o holds 8;
  - on release, PCs 0, 4, 8 are delivered in order with no loss or duplication.
- Redirect to 32'h0000_0103 while buffer holds 2 entries:
  - inst_valid_o=0 in the redirect cycle;
  - next cycle imem_addr_o=13'h100, buffer empty;
  - first delivered inst_pc_o=32'h0000_0100.
- fetch_en_i=0 with 2 buffered entries and inst_ready_i=1:
  - both drain, then inst_valid_o=0 and imem_addr_o stays constant;
  - fetch_en_i=1 resumes at the held PC.
- pc_q reaching 32'h0000_1FFC (IMEM_W=13): next fetch PC=32'h0000_2000 with imem_addr_o=0 (alias).
- Assert rst_i asynchronously mid-stream with a full buffer:
  - outputs go to reset values immediately, before the next edge;
  - after release the sequence restarts from RESET_PC via ST_BOOT.
